// File: rtl/alu_pkg.sv
// Shared encodings for the execute-stage ALU: opcodes, lane widths, operand forms.
package alu_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b100;
    localparam logic [2:0] OP_MULT = 3'b001;
    localparam logic [2:0] OP_DIV  = 3'b101;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b110;
    localparam logic [2:0] OP_COPY = 3'b111;

    localparam logic [1:0] VEC8  = 2'd0;
    localparam logic [1:0] VEC16 = 2'd1;
    localparam logic [1:0] VEC32 = 2'd2;
    localparam logic [1:0] VEC64 = 2'd3;

    localparam logic FORM_PAIR   = 1'b0;
    localparam logic FORM_SCALAR = 1'b1;

    // True when byte b of a 64-bit word begins a new lane for the given width.
    function automatic logic lane_start(input int unsigned b, input logic [1:0] vec);
        case (vec)
            VEC8:    return 1'b1;
            VEC16:   return (b % 2) == 0;
            VEC32:   return (b % 4) == 0;
            default: return b == 0;
        endcase
    endfunction

endpackage

// File: rtl/alu_simd_addsub.sv
// 64-bit add/subtract built from byte slices; carries are killed at lane starts.
module alu_simd_addsub
    import alu_pkg::*;
(
    input  logic [63:0] x,
    input  logic [63:0] y,
    input  logic        sub,
    input  logic [1:0]  vec,
    output logic [63:0] sum
);

    // Subtraction is x + ~y + 1, with the +1 injected at every lane start.
    logic [63:0] y_eff;
    logic [7:0]  cout;
    logic        unused_top_carry;

    assign y_eff            = y ^ {64{sub}};
    assign unused_top_carry = cout[7];

    for (genvar i = 0; i < 8; i++) begin : g_byte
        logic       cin;
        logic [8:0] s;
        if (i == 0) begin : g_first
            assign cin = sub;
        end else begin : g_rest
            assign cin = lane_start(i, vec) ? sub : cout[i-1];
        end
        assign s              = {1'b0, x[i*8 +: 8]} + {1'b0, y_eff[i*8 +: 8]} + {8'd0, cin};
        assign sum[i*8 +: 8]  = s[7:0];
        assign cout[i]        = s[8];
    end

endmodule

// File: rtl/alu.sv
// Registered dual-output integer ALU: paired/SIMD and scalar three-operand forms.
module alu
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  op,
    input  logic        form,
    input  logic [1:0]  vec,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [31:0] C,
    input  logic [31:0] D,
    input  logic [3:0]  logic_select,
    output logic [31:0] Y1,
    output logic [31:0] Y2
);

    // Paired operands: high word feeds Y1, low word feeds Y2, so a 64-bit lane
    // spans both and narrower lanes never cross the word boundary.
    logic [63:0] x_pair, y_pair;
    logic [63:0] a_sx, b_sx, c_sx;
    logic        is_sub;
    logic        unused_sel;

    assign x_pair     = {A, B};
    assign y_pair     = {C, D};
    assign a_sx       = {{32{A[31]}}, A};
    assign b_sx       = {{32{B[31]}}, B};
    assign c_sx       = {{32{C[31]}}, C};
    assign is_sub     = (op == OP_SUB);
    assign unused_sel = logic_select[3];

    // Add/sub: one lanewise pass for form 0, two chained 64-bit passes for form 1.
    logic [63:0] sum_pair, sum_ab, sum_abc;

    alu_simd_addsub u_pair (
        .x   (x_pair),
        .y   (y_pair),
        .sub (is_sub),
        .vec (vec),
        .sum (sum_pair)
    );

    alu_simd_addsub u_scalar_ab (
        .x   (a_sx),
        .y   (b_sx),
        .sub (is_sub),
        .vec (VEC64),
        .sum (sum_ab)
    );

    alu_simd_addsub u_scalar_abc (
        .x   (sum_ab),
        .y   (c_sx),
        .sub (is_sub),
        .vec (VEC64),
        .sum (sum_abc)
    );

    // Lanewise low-half multiply; low bits are identical for signed and unsigned.
    logic [63:0] mul_pair;
    always_comb begin
        mul_pair = '0;
        case (vec)
            VEC8:
                for (int i = 0; i < 8; i++)
                    mul_pair[i*8 +: 8] = x_pair[i*8 +: 8] * y_pair[i*8 +: 8];
            VEC16:
                for (int i = 0; i < 4; i++)
                    mul_pair[i*16 +: 16] = x_pair[i*16 +: 16] * y_pair[i*16 +: 16];
            VEC32:
                for (int i = 0; i < 2; i++)
                    mul_pair[i*32 +: 32] = x_pair[i*32 +: 32] * y_pair[i*32 +: 32];
            default:
                mul_pair = x_pair * y_pair;
        endcase
    end

    // Scalar signed 32x32 multiply-accumulate into 64 bits.
    logic signed [63:0] mac;
    assign mac = $signed(a_sx) * $signed(b_sx) + $signed(c_sx);

    // Lanewise unsigned divide; a zero divisor yields an all-ones lane.
    logic [63:0] div_pair;
    always_comb begin
        div_pair = '0;
        case (vec)
            VEC8:
                for (int i = 0; i < 8; i++)
                    div_pair[i*8 +: 8] = (y_pair[i*8 +: 8] == '0) ? '1
                                       : x_pair[i*8 +: 8] / y_pair[i*8 +: 8];
            VEC16:
                for (int i = 0; i < 4; i++)
                    div_pair[i*16 +: 16] = (y_pair[i*16 +: 16] == '0) ? '1
                                         : x_pair[i*16 +: 16] / y_pair[i*16 +: 16];
            VEC32:
                for (int i = 0; i < 2; i++)
                    div_pair[i*32 +: 32] = (y_pair[i*32 +: 32] == '0) ? '1
                                         : x_pair[i*32 +: 32] / y_pair[i*32 +: 32];
            default:
                div_pair = (y_pair == '0) ? '1 : x_pair / y_pair;
        endcase
    end

    // Scalar unsigned divide with remainder; B=0 returns all-ones and passes A through.
    logic [63:0] div_scalar;
    assign div_scalar = (B == '0) ? {32'hFFFF_FFFF, A} : {A / B, A % B};

    // Logic ops are always per 32-bit word with optional operand/result inversion.
    logic [31:0] a_l, b_l, c_l, d_l, lg1, lg2;
    always_comb begin
        a_l = logic_select[0] ? ~A : A;
        b_l = logic_select[0] ? ~B : B;
        c_l = logic_select[1] ? ~C : C;
        d_l = logic_select[1] ? ~D : D;
        case (op)
            OP_AND:  begin lg1 = a_l & c_l; lg2 = b_l & d_l; end
            OP_OR:   begin lg1 = a_l | c_l; lg2 = b_l | d_l; end
            OP_XOR:  begin lg1 = a_l ^ c_l; lg2 = b_l ^ d_l; end
            default: begin lg1 = a_l;       lg2 = b_l;       end
        endcase
        if (logic_select[2]) begin
            lg1 = ~lg1;
            lg2 = ~lg2;
        end
    end

    // Select the 64-bit result for the current op and form.
    logic [63:0] res;
    always_comb begin
        res = '0;
        case (op)
            OP_ADD, OP_SUB: res = (form == FORM_SCALAR) ? sum_abc : sum_pair;
            OP_MULT:        res = (form == FORM_SCALAR) ? mac : mul_pair;
            OP_DIV:         res = (form == FORM_SCALAR) ? div_scalar : div_pair;
            default:        res = {lg1, lg2};
        endcase
    end

    // Output register; synchronous reset takes priority over the new result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            Y1 <= '0;
            Y2 <= '0;
        end else begin
            Y1 <= res[63:32];
            Y2 <= res[31:0];
        end
    end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed plan cases plus randomized model comparison.
module tb_alu;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  op;
    logic        form;
    logic [1:0]  vec;
    logic [31:0] A, B, C, D;
    logic [3:0]  logic_select;
    logic [31:0] Y1, Y2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    alu dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .op           (op),
        .form         (form),
        .vec          (vec),
        .A            (A),
        .B            (B),
        .C            (C),
        .D            (D),
        .logic_select (logic_select),
        .Y1           (Y1),
        .Y2           (Y2)
    );

    // Reference: generic lane slicing with shifts/masks and wide plain arithmetic.
    function automatic logic [63:0] model(input logic [2:0] o, input logic f, input logic [1:0] v,
                                          input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] c, input logic [31:0] d,
                                          input logic [3:0] ls);
        logic [63:0] x, y, r, mask, xl, yl, rl;
        logic [127:0] p;
        logic [31:0] ap, bp, cp, dp, r1, r2;
        longint sa, sb, sc;
        int w, n;
        if (o == OP_AND || o == OP_OR || o == OP_XOR || o == OP_COPY) begin
            ap = ls[0] ? ~a : a;  bp = ls[0] ? ~b : b;
            cp = ls[1] ? ~c : c;  dp = ls[1] ? ~d : d;
            if (o == OP_AND)      begin r1 = ap & cp; r2 = bp & dp; end
            else if (o == OP_OR)  begin r1 = ap | cp; r2 = bp | dp; end
            else if (o == OP_XOR) begin r1 = ap ^ cp; r2 = bp ^ dp; end
            else                  begin r1 = ap;      r2 = bp;      end
            if (ls[2]) begin r1 = ~r1; r2 = ~r2; end
            return {r1, r2};
        end
        if (f) begin
            sa = longint'($signed(a)); sb = longint'($signed(b)); sc = longint'($signed(c));
            if (o == OP_ADD)  return 64'(sa + sb + sc);
            if (o == OP_SUB)  return 64'(sa - sb - sc);
            if (o == OP_MULT) return 64'(sa * sb + sc);
            if (b == 0) return {32'hFFFF_FFFF, a};
            return {a / b, a % b};
        end
        w = 8 << v;
        n = 64 / w;
        mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        x = {a, b};
        y = {c, d};
        r = '0;
        for (int k = 0; k < n; k++) begin
            xl = (x >> (k * w)) & mask;
            yl = (y >> (k * w)) & mask;
            if (o == OP_ADD)       rl = xl + yl;
            else if (o == OP_SUB)  rl = xl - yl;
            else if (o == OP_MULT) begin p = xl * yl; rl = p[63:0]; end
            else                   rl = (yl == 0) ? mask : xl / yl;
            r = r | ((rl & mask) << (k * w));
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic apply(input logic [2:0] o, input logic f, input logic [1:0] v,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input logic [31:0] d, input logic [3:0] ls);
        @(negedge clk);
        op = o; form = f; vec = v; A = a; B = b; C = c; D = d; logic_select = ls;
        @(posedge clk);
        #1;
    endtask

    // Apply one op, then compare against a plan constant.
    task automatic directed(input string tag, input logic [2:0] o, input logic f, input logic [1:0] v,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] c, input logic [31:0] d,
                            input logic [3:0] ls, input logic [63:0] exp);
        apply(o, f, v, a, b, c, d, ls);
        check(tag, {Y1, Y2}, exp);
    endtask

    initial begin
        logic [2:0]  r_op;
        logic        r_form;
        logic [1:0]  r_vec;
        logic [31:0] ra, rb, rc, rd;
        logic [3:0]  rls;

        rst_n = 1'b0;
        op = OP_ADD; form = FORM_SCALAR; vec = VEC32;
        A = 32'd1; B = 32'd2; C = 32'd3; D = 32'd2; logic_select = 4'd0;

        // Reset held for two edges with live inputs.
        @(posedge clk); #1;
        check("reset_edge1", {Y1, Y2}, 64'd0);
        @(posedge clk); #1;
        check("reset_edge2", {Y1, Y2}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("first_after_reset", {Y1, Y2}, 64'd6);

        directed("add_f1",       OP_ADD, FORM_SCALAR, VEC32, 1, 2, 3, 2, 0, 64'd6);
        directed("add_f0_v32",   OP_ADD, FORM_PAIR,   VEC32, 1, 2, 3, 2, 0, {32'd4, 32'd4});
        directed("add_f0_v64",   OP_ADD, FORM_PAIR,   VEC64, 1, 2, 3, 2, 0, {32'h4, 32'h4});
        directed("add_f0_v16",   OP_ADD, FORM_PAIR,   VEC16, 1, 2, 3, 2, 0, {32'd4, 32'd4});
        directed("sub_f1",       OP_SUB, FORM_SCALAR, VEC32, 1, 2, 3, 2, 0, 64'hFFFF_FFFF_FFFF_FFFC);
        directed("sub_f0_v32",   OP_SUB, FORM_PAIR,   VEC32, 1, 2, 3, 2, 0, {32'hFFFF_FFFE, 32'd0});
        directed("lane_iso_v8",  OP_ADD, FORM_PAIR,   VEC8,  32'hFF, 0, 32'h1, 0, 0, {32'h0, 32'h0});
        directed("lane_iso_v32", OP_ADD, FORM_PAIR,   VEC32, 32'hFF, 0, 32'h1, 0, 0, {32'h100, 32'h0});
        directed("word_iso_v32", OP_ADD, FORM_PAIR,   VEC32, 0, 32'hFFFF_FFFF, 0, 32'h1, 0, 64'd0);
        directed("word_carry_v64", OP_ADD, FORM_PAIR, VEC64, 0, 32'hFFFF_FFFF, 0, 32'h1, 0, {32'h1, 32'h0});
        directed("mac_f1",       OP_MULT, FORM_SCALAR, VEC32, -32'sd2, 3, 10, 0, 0, 64'd4);
        directed("div_f1",       OP_DIV, FORM_SCALAR, VEC32, 17, 5, 0, 0, 0, {32'd3, 32'd2});
        directed("div_f1_zero",  OP_DIV, FORM_SCALAR, VEC32, 9, 0, 0, 0, 0, {32'hFFFF_FFFF, 32'd9});
        directed("div_f0_zero",  OP_DIV, FORM_PAIR,   VEC8,  32'h10_20_30_40, 0, 32'h02_00_05_00, 0, 0,
                 {32'h08_FF_09_FF, 32'hFFFF_FFFF});
        directed("and",          OP_AND, FORM_PAIR, VEC32, 32'hF0F0F0F0, 0, 32'hFF00FF00, 0, 4'b0000,
                 {32'hF000F000, 32'h0});
        directed("and_inv",      OP_AND, FORM_PAIR, VEC32, 32'hF0F0F0F0, 0, 32'hFF00FF00, 0, 4'b0100,
                 {32'h0FFF0FFF, 32'hFFFF_FFFF});
        directed("copy_inv_a",   OP_COPY, FORM_SCALAR, VEC8, 32'hF0F0F0F0, 0, 32'hFF00FF00, 0, 4'b0001,
                 {32'h0F0F0F0F, 32'hFFFF_FFFF});

        // Randomized ops, forms, widths and operands, back to back every cycle.
        for (int i = 0; i < 400; i++) begin
            r_op = 3'($urandom_range(0, 7));
            r_form = 1'($urandom_range(0, 1));
            r_vec = 2'($urandom_range(0, 3));
            ra = $urandom; rb = $urandom; rc = $urandom; rd = $urandom;
            rls = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) begin
                rb = rb & 32'h0000_00F0;
                rc = rc & 32'hFF00_0F00;
                rd = rd & 32'h00F0_00FF;
            end
            apply(r_op, r_form, r_vec, ra, rb, rc, rd, rls);
            check($sformatf("rand%0d_op%0d_f%0d_v%0d", i, r_op, r_form, r_vec),
                  {Y1, Y2}, model(r_op, r_form, r_vec, ra, rb, rc, rd, rls));
        end

        // Reset at the same edge as a valid operation: reset wins.
        @(negedge clk);
        rst_n = 1'b0;
        op = OP_ADD; form = FORM_PAIR; vec = VEC32;
        A = 32'h1234; B = 32'h5678; C = 32'h1; D = 32'h1;
        @(posedge clk); #1;
        check("reset_wins", {Y1, Y2}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
